// File: rtl/game_display_box_animator.sv
// Game-display box animator: walks the four box edges toward an accepted target
// by at most STEP pixels per frame_tick. Optional GAME_DISPLAY_SNAP_EN adds a snap input.
module game_display_box_animator #(
  parameter int STEP    = 4,
  parameter int BORDER  = 5,
  parameter int H_MAX   = 639,
  parameter int V_MAX   = 479,
  parameter int INIT_X0 = 220,
  parameter int INIT_Y0 = 250,
  parameter int INIT_X1 = 420,
  parameter int INIT_Y1 = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic [9:0] target_x0,
  input  logic [9:0] target_y0,
  input  logic [9:0] target_x1,
  input  logic [9:0] target_y1,
`ifdef GAME_DISPLAY_SNAP_EN
  input  logic       snap,
`endif
  output logic [9:0] game_display_x0,
  output logic [9:0] game_display_y0,
  output logic [9:0] game_display_x1,
  output logic [9:0] game_display_y1,
  output logic       moving,
  output logic       done,
  output logic       reject
);

  typedef enum logic {S_IDLE, S_MOVE} state_t;

  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic        [9:0]  STEP_U   = 10'(STEP);
  localparam logic        [10:0] BORDER_W = 11'(BORDER);
  localparam logic        [10:0] H_MAX_W  = 11'(H_MAX);
  localparam logic        [10:0] V_MAX_W  = 11'(V_MAX);

  state_t     state_q, state_d;
  logic [9:0] x0_q, y0_q, x1_q, y1_q;
  logic [9:0] x0_d, y0_d, x1_d, y1_d;
  logic [9:0] tx0_q, ty0_q, tx1_q, ty1_q;
  logic [9:0] tx0_d, ty0_d, tx1_d, ty1_d;
  logic       ready_q, ready_d;
  logic       moving_q, moving_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       snap_w;
  logic       legal;
  logic       same_box;
  logic       arrive;
  logic [9:0] nx0, ny0, nx1, ny1;
  logic [10:0] rx0, ry0, rx1, ry1;

`ifdef GAME_DISPLAY_SNAP_EN
  assign snap_w = snap;
`else
  assign snap_w = 1'b0;
`endif

  // Move one edge toward its target, clamping the step so it never overshoots.
  function automatic logic [9:0] step_edge(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       step_edge = cur + STEP_U;
    else if (diff < -STEP_S) step_edge = cur - STEP_U;
    else                     step_edge = tgt;
  endfunction

  always_comb begin
    rx0 = {1'b0, target_x0};
    ry0 = {1'b0, target_y0};
    rx1 = {1'b0, target_x1};
    ry1 = {1'b0, target_y1};
    legal = (rx0 >= BORDER_W) && (ry0 >= BORDER_W) && (rx0 < rx1) && (ry0 < ry1) &&
            (rx1 + BORDER_W <= H_MAX_W) && (ry1 + BORDER_W <= V_MAX_W);
    same_box = (target_x0 == x0_q) && (target_y0 == y0_q) &&
               (target_x1 == x1_q) && (target_y1 == y1_q);
    nx0 = step_edge(x0_q, tx0_q);
    ny0 = step_edge(y0_q, ty0_q);
    nx1 = step_edge(x1_q, tx1_q);
    ny1 = step_edge(y1_q, ty1_q);
    arrive = (nx0 == tx0_q) && (ny0 == ty0_q) && (nx1 == tx1_q) && (ny1 == ty1_q);
  end

  always_comb begin
    state_d  = state_q;
    x0_d = x0_q;  y0_d = y0_q;  x1_d = x1_q;  y1_d = y1_q;
    tx0_d = tx0_q; ty0_d = ty0_q; tx1_d = tx1_q; ty1_d = ty1_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (target_valid) begin
          if (!legal) begin
            reject_d = 1'b1;
          end else if (same_box) begin
            done_d = 1'b1;
          end else if (snap_w) begin
            x0_d = target_x0; y0_d = target_y0; x1_d = target_x1; y1_d = target_y1;
            done_d = 1'b1;
          end else begin
            tx0_d = target_x0; ty0_d = target_y0; tx1_d = target_x1; ty1_d = target_y1;
            state_d = S_MOVE;
          end
        end
      end
      default: begin
        if (snap_w) begin
          x0_d = tx0_q; y0_d = ty0_q; x1_d = tx1_q; y1_d = ty1_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (frame_tick) begin
          x0_d = nx0; y0_d = ny0; x1_d = nx1; y1_d = ny1;
          if (arrive) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
    endcase
    ready_d  = (state_d == S_IDLE);
    moving_d = (state_d == S_MOVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x0_q     <= 10'(INIT_X0);
      y0_q     <= 10'(INIT_Y0);
      x1_q     <= 10'(INIT_X1);
      y1_q     <= 10'(INIT_Y1);
      ready_q  <= 1'b1;
      moving_q <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      ready_q  <= ready_d;
      moving_q <= moving_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
    // Target latches carry data only; a reset simply abandons them via IDLE.
    tx0_q <= tx0_d;
    ty0_q <= ty0_d;
    tx1_q <= tx1_d;
    ty1_q <= ty1_d;
  end

  assign target_ready    = ready_q;
  assign moving          = moving_q;
  assign done            = done_q;
  assign reject          = reject_q;
  assign game_display_x0 = x0_q;
  assign game_display_y0 = y0_q;
  assign game_display_x1 = x1_q;
  assign game_display_y1 = y1_q;

endmodule

// File: tb/tb_game_display_box_animator.sv
// Scoreboard bench for game_display_box_animator; a behavioural model pushes the
// expected post-edge outputs each cycle and the sampled DUT outputs are popped against them.
module tb_game_display_box_animator;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       reset, frame_tick, target_valid, target_ready;
  logic [9:0] target_x0, target_y0, target_x1, target_y1;
  logic [9:0] gx0, gy0, gx1, gy1;
  logic       moving, done, reject;
`ifdef GAME_DISPLAY_SNAP_EN
  logic       snap;
`endif

  game_display_box_animator dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .target_valid(target_valid), .target_ready(target_ready),
    .target_x0(target_x0), .target_y0(target_y0),
    .target_x1(target_x1), .target_y1(target_y1),
`ifdef GAME_DISPLAY_SNAP_EN
    .snap(snap),
`endif
    .game_display_x0(gx0), .game_display_y0(gy0),
    .game_display_x1(gx1), .game_display_y1(gy1),
    .moving(moving), .done(done), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, x1, y1;
    bit rdy, mov, dn, rj;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_c[4];
  int   m_t[4];
  bit   m_move;
  bit   m_done, m_rej;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    int d;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (d > STEP) d = STEP;
    return (tgt > cur) ? cur + d : cur - d;
  endfunction

  task automatic model(input bit ft, input bit tv, input int a, input int b,
                       input int c, input int d, input bit sn, input bit rs);
    bit lg;
    m_done = 0;
    m_rej  = 0;
    if (rs) begin
      m_c[0] = 220; m_c[1] = 250; m_c[2] = 420; m_c[3] = 400;
      m_move = 0;
    end else if (!m_move) begin
      if (tv) begin
        lg = (a >= 5) && (b >= 5) && (a < c) && (b < d) && (c + 5 <= 639) && (d + 5 <= 479);
        if (!lg) m_rej = 1;
        else if (a == m_c[0] && b == m_c[1] && c == m_c[2] && d == m_c[3]) m_done = 1;
        else if (sn) begin
          m_c[0] = a; m_c[1] = b; m_c[2] = c; m_c[3] = d; m_done = 1;
        end else begin
          m_t[0] = a; m_t[1] = b; m_t[2] = c; m_t[3] = d; m_move = 1;
        end
      end
    end else if (sn) begin
      for (int i = 0; i < 4; i++) m_c[i] = m_t[i];
      m_done = 1; m_move = 0;
    end else if (ft) begin
      for (int i = 0; i < 4; i++) m_c[i] = toward(m_c[i], m_t[i]);
      if (m_c[0] == m_t[0] && m_c[1] == m_t[1] && m_c[2] == m_t[2] && m_c[3] == m_t[3]) begin
        m_done = 1; m_move = 0;
      end
    end
  endtask

  task automatic cyc(input bit ft, input bit tv, input int a, input int b,
                     input int c, input int d, input bit sn, input bit rs);
    exp_t e;
    frame_tick   = ft;
    target_valid = tv;
    target_x0 = 10'(a); target_y0 = 10'(b); target_x1 = 10'(c); target_y1 = 10'(d);
    reset = rs;
`ifdef GAME_DISPLAY_SNAP_EN
    snap = sn;
`endif
    model(ft, tv, a, b, c, d, sn, rs);
    e.x0 = m_c[0]; e.y0 = m_c[1]; e.x1 = m_c[2]; e.y1 = m_c[3];
    e.rdy = !m_move; e.mov = m_move; e.dn = m_done; e.rj = m_rej;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("x0", 32'(gx0), 32'(e.x0));
    chk("y0", 32'(gy0), 32'(e.y0));
    chk("x1", 32'(gx1), 32'(e.x1));
    chk("y1", 32'(gy1), 32'(e.y1));
    chk("target_ready", 32'(target_ready), 32'(e.rdy));
    chk("moving", 32'(moving), 32'(e.mov));
    chk("done", 32'(done), 32'(e.dn));
    chk("reject", 32'(reject), 32'(e.rj));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic offer(input int a, input int b, input int c, input int d);
    cyc(0, 1, a, b, c, d, 0, 0);
  endtask

  // Run random ticks (with stray offers) until the model is back in IDLE.
  task automatic run_to_idle();
    int i;
    for (i = 0; i < 2000 && m_move; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 100, 100, 200, 200, 0, 0);
    if (m_move) chk("move_timeout", 1, 0);
  endtask

  initial begin
    int ticks;
    int a, b, c, d;
    m_move = 0;
    frame_tick = 0; target_valid = 0; reset = 1;
    target_x0 = 0; target_y0 = 0; target_x1 = 0; target_y1 = 0;
`ifdef GAME_DISPLAY_SNAP_EN
    snap = 0;
`endif
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 300, 250, 340, 400, 0, 1);
    chk("rst_x0", 32'(gx0), 220);
    chk("rst_y1", 32'(gy1), 400);
    idle(2);

    offer(220, 250, 420, 400);
    idle(2);

    // Acceptance coincident with a tick: the tick must not move anything.
    cyc(1, 1, 300, 250, 340, 400, 0, 0);
    ticks = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      cyc(1, 1, 5, 5, 600, 400, 0, 0);
      ticks++;
      if (!done) begin
        cyc(0, 1, 5, 5, 600, 400, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    chk("latency_ticks", 32'(ticks), 20);
    chk("arrived_x0", 32'(gx0), 300);
    chk("arrived_x1", 32'(gx1), 340);
    idle(2);

    offer(3, 250, 420, 400);
    offer(220, 250, 638, 400);
    offer(220, 4, 420, 400);
    offer(420, 250, 420, 400);
    offer(220, 400, 420, 400);
    offer(220, 250, 420, 475);
    idle(1);

    offer(5, 5, 634, 474);
    run_to_idle();
    idle(1);
    offer(220, 250, 420, 400);
    run_to_idle();
    idle(1);

    offer(300, 250, 340, 400);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("midmove_rst_x0", 32'(gx0), 220);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      a = $urandom_range(3, 300);
      b = $urandom_range(3, 240);
      c = a + $urandom_range(0, 340);
      d = b + $urandom_range(0, 240);
      cyc(1'($urandom_range(0, 1)), 1, a, b, c, d, 0, 0);
      run_to_idle();
      idle($urandom_range(0, 2));
    end

`ifdef GAME_DISPLAY_SNAP_EN
    cyc(0, 1, 100, 100, 200, 200, 1, 0);
    chk("snap_x0", 32'(gx0), 100);
    idle(1);
    offer(300, 250, 340, 400);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("snap_mv_x1", 32'(gx1), 340);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
